// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - shared constants and bus word type for the register block
//
// Contents:
//   DEFAULT_WIDTH  - default data/storage width in bits (8)
//   LOAD_ACTIVE    - level of load that captures data (active-low)
//   ENABLE_ACTIVE  - level of enable that drives the stored value onto q (active-low)
//   data_word_t    - data-bus word at the default width

package sap_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic LOAD_ACTIVE   = 1'b0;
    localparam logic ENABLE_ACTIVE = 1'b0;

    typedef logic [DEFAULT_WIDTH-1:0] data_word_t;

endpackage

// File: rtl/register_out_drv.sv
// rtl/register_out_drv.sv - enable-gated output stage for the register block
//
// Parameters:
//   WIDTH  - bus width in bits (minimum 1)
// Ports:
//   enable - input,  1     : output enable, active-low
//   value  - input,  WIDTH : stored value to present
//   q      - output, WIDTH : bus-side view; value when enabled, disabled level otherwise
//
// Build option REGISTER_TRISTATE_EN:
//   defined   - disabled level is high-impedance, for a shared wired bus
//   undefined - disabled level is all zeros, for an OR/mux-based bus

module register_out_drv
    import sap_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             enable,
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] q
);

    // Purely combinational: q follows enable and the stored value with no
    // extra cycle, so a load is visible on q in the same cycle it lands.
`ifdef REGISTER_TRISTATE_EN
    assign q = (enable == ENABLE_ACTIVE) ? value : {WIDTH{1'bz}};
`else
    assign q = (enable == ENABLE_ACTIVE) ? value : {WIDTH{1'b0}};
`endif

endmodule

// File: rtl/register.sv
// rtl/register.sv - WIDTH-bit load/clear register with enable-gated bus output
//
// Parameters:
//   WIDTH  - data and storage width in bits (default 8, minimum 1)
// Ports:
//   clk    - input,  1     : clock, all state changes on rising edge
//   clr    - input,  1     : synchronous active-high clear (highest priority)
//   load   - input,  1     : active-low load strobe
//   enable - input,  1     : active-low output enable
//   data   - input,  WIDTH : parallel value to capture
//   q      - output, WIDTH : stored value when enabled, disabled level otherwise
//
// Build option REGISTER_TRISTATE_EN selects the disabled level of q
// (high-impedance when defined, zeros when undefined); storage is unaffected.
// Stored value is undefined until the first clocked clr.

module register
    import sap_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stored;

    // Priority clr > load > hold. enable never touches storage, so loads and
    // clears carry on while the output is disabled.
    always_ff @(posedge clk) begin
        if (clr) begin
            stored <= '0;
        end else if (load == LOAD_ACTIVE) begin
            stored <= data;
        end
    end

    register_out_drv #(
        .WIDTH (WIDTH)
    ) u_out_drv (
        .enable (enable),
        .value  (stored),
        .q      (q)
    );

endmodule

// File: tb/tb_register.sv
// tb/tb_register.sv - directed self-checking bench for register

module tb_register;

`ifdef REGISTER_TRISTATE_EN
    localparam logic [7:0] DIS = 8'hzz;
`else
    localparam logic [7:0] DIS = 8'h00;
`endif

    logic       clk;
    logic       clr;
    logic       load;
    logic       enable;
    logic [7:0] data;
    wire  [7:0] q;

    int passed;
    int total;

    register #(.WIDTH(8)) dut (
        .clk    (clk),
        .clr    (clr),
        .load   (load),
        .enable (enable),
        .data   (data),
        .q      (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1; load = 1'b0; enable = 1'b0; data = 8'h00;
        tick();
        clr = 1'b0; load = 1'b1;
        #1;
        total++;
        if (q !== 8'h00) $display("FAIL reset_q: got %h expected %h", q, 8'h00);
        else passed++;
    endtask

    task automatic test_load_hold();
        load = 1'b0; data = 8'hFF;
        tick();
        total++;
        if (q !== 8'hFF) $display("FAIL load_ff: got %h expected %h", q, 8'hFF);
        else passed++;

        load = 1'b1; data = 8'h55;
        tick();
        total++;
        if (q !== 8'hFF) $display("FAIL hold_ignores_data: got %h expected %h", q, 8'hFF);
        else passed++;

        load = 1'b0; data = 8'h03;
        tick();
        load = 1'b1;
        total++;
        if (q !== 8'h03) $display("FAIL load_03: got %h expected %h", q, 8'h03);
        else passed++;
    endtask

    task automatic test_output_enable();
        enable = 1'b1;
        #1;
        total++;
        if (q !== DIS) $display("FAIL disabled_level: got %h expected %h", q, DIS);
        else passed++;

        enable = 1'b0;
        #1;
        total++;
        if (q !== 8'h03) $display("FAIL reenable_no_edge: got %h expected %h", q, 8'h03);
        else passed++;

        // enable toggling across edges with load inactive must not disturb storage
        enable = 1'b1; data = 8'hC3;
        tick();
        enable = 1'b0;
        tick();
        total++;
        if (q !== 8'h03) $display("FAIL enable_toggle_keeps: got %h expected %h", q, 8'h03);
        else passed++;
    endtask

    task automatic test_clear_while_disabled();
        enable = 1'b1; clr = 1'b1;
        tick();
        clr = 1'b0;
        total++;
        if (q !== DIS) $display("FAIL clr_disabled_q: got %h expected %h", q, DIS);
        else passed++;
        enable = 1'b0;
        #1;
        total++;
        if (q !== 8'h00) $display("FAIL clr_disabled_stored: got %h expected %h", q, 8'h00);
        else passed++;
    endtask

    task automatic test_load_while_disabled();
        enable = 1'b1; load = 1'b0; data = 8'h5A;
        tick();
        load = 1'b1;
        total++;
        if (q !== DIS) $display("FAIL load_disabled_q: got %h expected %h", q, DIS);
        else passed++;
        enable = 1'b0;
        #1;
        total++;
        if (q !== 8'h5A) $display("FAIL load_disabled_stored: got %h expected %h", q, 8'h5A);
        else passed++;
    endtask

    task automatic test_clear_priority();
        clr = 1'b1; load = 1'b0; data = 8'hAA;
        tick();
        clr = 1'b0; load = 1'b1;
        total++;
        if (q !== 8'h00) $display("FAIL clr_over_load: got %h expected %h", q, 8'h00);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] vec [4];
        logic [7:0] exp [4];
        logic       clr_v [4];
        vec[0] = 8'h11; clr_v[0] = 1'b0; exp[0] = 8'h11;
        vec[1] = 8'h22; clr_v[1] = 1'b0; exp[1] = 8'h22;
        vec[2] = 8'h33; clr_v[2] = 1'b1; exp[2] = 8'h00;
        vec[3] = 8'h80; clr_v[3] = 1'b0; exp[3] = 8'h80;
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            load = 1'b0; data = vec[i]; clr = clr_v[i];
            tick();
            total++;
            if (q !== exp[i]) $display("FAIL b2b_%0d: got %h expected %h", i, q, exp[i]);
            else passed++;
        end
        load = 1'b1; clr = 1'b0; data = 8'h7E;
        tick();
        total++;
        if (q !== 8'h80) $display("FAIL b2b_hold: got %h expected %h", q, 8'h80);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        clr = 1'b0; load = 1'b1; enable = 1'b0; data = 8'h00;
        #2;
        test_reset();
        test_load_hold();
        test_output_enable();
        test_clear_while_disabled();
        test_load_while_disabled();
        test_clear_priority();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/register.md
REGISTER -- requirements
Module: register

Interface
REQ-001 SHALL provide parameter WIDTH, default 8: data and storage width in bits, minimum 1.
REQ-002 SHALL provide port clk, input, 1: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL provide port clr, input, 1: reset, synchronous and active-high, sampled on the rising edge of clk.
REQ-004 SHALL provide port load, input, 1: load strobe, active-low (0 = capture data).
REQ-005 SHALL provide port enable, input, 1: output enable, active-low (0 = drive q).
REQ-006 SHALL provide port data, input, WIDTH: parallel value to capture.
REQ-007 SHALL provide port q, output, WIDTH: bus-side view of the stored value.

Function
REQ-008 SHALL hold one WIDTH-bit internal stored value, updated only on the rising edge of clk.
REQ-009 On a rising edge with clr=1, the stored value SHALL become all zeros, regardless of load, enable and data.
REQ-010 On a rising edge with clr=0 and load=0, the stored value SHALL become data (1-cycle load latency).
REQ-011 On a rising edge with clr=0 and load=1, the stored value SHALL be held unchanged; data is ignored.
REQ-012 Priority SHALL be clr > load > hold; clr=1 with load=0 in the same cycle SHALL yield zero.
REQ-013 q SHALL be combinational from enable and the stored value, with no added cycle of delay.
REQ-014 With enable=0, q SHALL equal the stored value; it SHALL update in the same cycle as the stored value.
REQ-015 With enable=1, q SHALL present the disabled level defined under Configuration.
REQ-016 Toggling enable SHALL NOT alter the stored value.
REQ-017 Loads and clears SHALL proceed normally while the output is disabled.
REQ-018 Full-width data SHALL be captured with no truncation or sign handling; 8'hFF in SHALL read back as 8'hFF.

Reset
REQ-019 Reset SHALL be synchronous and active-high on clr; no asynchronous reset path SHALL exist.
REQ-020 After a clocked clr, the stored value SHALL be 0.
REQ-021 After a clocked clr, q SHALL be 0 when enable=0, or the disabled level when enable=1.
REQ-022 Before the first clocked clr, the stored value SHALL be undefined; users SHALL assert clr for at least one clk edge.
REQ-023 A clr arriving mid-sequence SHALL override any pending load on that edge.

Configuration
REQ-024 Macro REGISTER_TRISTATE_EN, when defined: q SHALL be high-impedance (all bits Z) while enable=1, for direct connection to a shared bus.
REQ-025 Macro REGISTER_TRISTATE_EN, when undefined: q SHALL drive all zeros while enable=1, for use with an OR/mux-based bus.
REQ-026 The macro SHALL affect only the disabled level of q.

Structure
REQ-027 A shared package sap_pkg SHALL hold the default data-width constant (8) and the active-low level constants for load and enable.
REQ-028 The data-bus word typedef SHALL also live in sap_pkg.
REQ-029 One sub-module, register_out_drv, SHALL implement the enable/tristate output stage; storage stays in register.

Verification
REQ-030 clr=1 across one edge, load=0, enable=0, data=8'h00 -> q=8'h00.
REQ-031 clr=0, load=0, enable=0, data=8'hFF, one edge -> q=8'hFF.
REQ-032 load=1, data=8'h55, one edge -> q stays 8'hFF.
REQ-033 load=0, data=8'h03, one edge -> q=8'h03.
REQ-034 enable=1 -> q=8'hZZ immediately (with macro) or 8'h00 (without macro).
REQ-035 Then enable=0 -> q=8'h03 again without a clock edge.
REQ-036 enable=1, clr=1, one edge, then enable=0 -> q=8'h00.
REQ-037 clr=1 and load=0 with data=8'hAA on the same edge -> q=8'h00.
